// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a fixed ROM of HDMI transmitter register writes on a start
// pulse. For each entry it presents {device address, register, value} to the I2C write
// controller, issues a one-cycle i2c_start_o, then waits for the controller's busy
// handshake. A short idle gap separates transactions.
//
// Ports:
//   clk_i        sequencer clock (250 kHz domain)
//   rst_i        synchronous active-high reset
//   start_i      one-cycle request to run the full sequence
//   i2c_busy_i   high while the I2C controller is transferring
//   address_o    7-bit I2C device address (constant DEV_ADDR)
//   data_0_o     register index of the current entry
//   data_1_o     register value of the current entry
//   i2c_start_o  one-cycle transaction request
//   busy_o       high from accepted start until done or error
//   done_o       level; all NUM_REGS entries completed
//   error_o      level; a handshake timeout occurred
//   index_o      ROM index of the entry in flight
module i2c_config_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned NUM_REGS    = 10,  // 1..16
  parameter int unsigned GAP_CYCLES  = 4,   // 1..255
  parameter int unsigned ACK_TIMEOUT = 16   // 2..255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       i2c_busy_i,
  output logic [6:0] address_o,
  output logic [7:0] data_0_o,
  output logic [7:0] data_1_o,
  output logic       i2c_start_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [3:0] index_o
);

  localparam logic [3:0] LastIdx = 4'(NUM_REGS - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
  // The i2c_start cycle itself counts toward the timeout, so ERROR is entered
  // ACK_TIMEOUT cycles after the request pulse.
  localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitAck,
    StWaitDone,
    StGap,
    StDone,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] index_q, index_d;
  logic [7:0] data0_q, data0_d;
  logic [7:0] data1_q, data1_d;
  logic       i2c_start_q, i2c_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [15:0] rom_word;

  // {register, value} table; entries beyond NUM_REGS are never addressed.
  function automatic logic [15:0] rom_entry(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h4110;
      4'd1:    word = 16'h9803;
      4'd2:    word = 16'h9AE0;
      4'd3:    word = 16'h9C30;
      4'd4:    word = 16'h9D61;
      4'd5:    word = 16'hA2A4;
      4'd6:    word = 16'hA3A4;
      4'd7:    word = 16'hE0D0;
      4'd8:    word = 16'hF900;
      4'd9:    word = 16'h1500;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  assign rom_word = rom_entry(index_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    data0_d = data0_q;
    data1_d = data1_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      // start is only honoured when not busy; DONE/ERROR restart from entry 0.
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d = StLoad;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = 4'd0;
        end
      end
      StLoad: begin
        data0_d = rom_word[15:8];
        data1_d = rom_word[7:0];
        state_d = StStart;
      end
      StStart: begin
        cnt_d   = 8'd0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (i2c_busy_i) begin
          state_d = StWaitDone;
        end else if (cnt_q >= AckLast) begin
          state_d = StError;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (!i2c_busy_i) begin
          cnt_d   = 8'd0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q >= GapLast) begin
          if (index_q >= LastIdx) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 4'd1;
            state_d = StLoad;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so the pulse coincides exactly with the START state.
    i2c_start_d = (state_d == StStart);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      index_q     <= 4'd0;
      data0_q     <= 8'd0;
      data1_q     <= 8'd0;
      i2c_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      i2c_start_q <= i2c_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Device address never changes, so it is tied rather than stored.
  assign address_o   = DEV_ADDR;
  assign data_0_o    = data0_q;
  assign data_1_o    = data1_q;
  assign i2c_start_o = i2c_start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign index_o     = index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer. A behavioural I2C controller answers each
// i2c_start one cycle later with 20 cycles of busy (optionally muted for one pulse).
// All inputs change and all outputs are sampled on the falling clock edge.
module tb_i2c_config_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       i2c_busy;
  logic [6:0] address;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       i2c_start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] index;

  i2c_config_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .i2c_busy_i  (i2c_busy),
    .address_o   (address),
    .data_0_o    (data_0),
    .data_1_o    (data_1),
    .i2c_start_o (i2c_start),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .index_o     (index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_reg [10] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D,
                               8'hA2, 8'hA3, 8'hE0, 8'hF9, 8'h15};
  logic [7:0] exp_val [10] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61,
                               8'hA4, 8'hA4, 8'hD0, 8'h00, 8'h00};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses = 0;
  int mute_pulse = 0;
  int rem = 0;
  int first_pulse_cyc = -1;
  int last_pulse_cyc = -1;
  int fall_cyc = -1;
  int gap_bad = 0;
  int gap_n = 0;
  int stab_bad = 0;
  int addr_bad = 0;
  int dbl_bad = 0;
  int s0, s1, s2, s3;
  logic       prev_start = 1'b0;
  logic       prev_busy_drv;
  logic [7:0] lat0 = 8'h00;
  logic [7:0] lat1 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/monitor the DUT, then play the controller for the next edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (address !== 7'h39) addr_bad++;
    if (rst) begin
      lat0 = 8'h00;
      lat1 = 8'h00;
    end else if (i2c_start === 1'b1) begin
      if (prev_start) dbl_bad++;
      if (pulses < 10) begin
        chk("data_0_seq", 32'(data_0), 32'(exp_reg[pulses]));
        chk("data_1_seq", 32'(data_1), 32'(exp_val[pulses]));
      end
      if (pulses == 0) first_pulse_cyc = cyc;
      if (fall_cyc >= 0) begin
        if (cyc - fall_cyc != 6) gap_bad++;
        gap_n++;
      end
      fall_cyc = -1;
      pulses++;
      last_pulse_cyc = cyc;
      lat0 = data_0;
      lat1 = data_1;
    end else if (data_0 !== lat0 || data_1 !== lat1) begin
      stab_bad++;
    end
    prev_start = i2c_start;

    prev_busy_drv = i2c_busy;
    if (rem > 0) begin
      i2c_busy = 1'b1;
      rem--;
    end else begin
      i2c_busy = 1'b0;
    end
    if (prev_busy_drv && !i2c_busy) fall_cyc = cyc;
    if (i2c_start === 1'b1 && !rst && pulses != mute_pulse) rem = 20;
  endtask

  task automatic new_run();
    pulses = 0;
    fall_cyc = -1;
    gap_bad = 0;
    gap_n = 0;
    first_pulse_cyc = -1;
    last_pulse_cyc = -1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    i2c_busy = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_address", 32'(address), 32'h39);
    chk("rst_data_0", 32'(data_0), 32'h0);
    chk("rst_data_1", 32'(data_1), 32'h0);
    chk("rst_i2c_start", 32'(i2c_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_index", 32'(index), 32'h0);
    rst = 1'b0;
    tick();

    // Nominal run: 10 entries, first pulse 2 cycles after start, 27-cycle period
    new_run();
    start = 1'b1;
    s0 = cyc;
    tick();
    start = 1'b0;
    chk("nom_busy_on", 32'(busy), 32'h1);
    chk("nom_done_off", 32'(done), 32'h0);
    for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
    chk("nom_done_cyc", 32'(cyc - s0), 32'd271);
    chk("nom_first_lat", 32'(first_pulse_cyc - s0), 32'd2);
    chk("nom_pulses", 32'(pulses), 32'd10);
    chk("nom_busy_off", 32'(busy), 32'h0);
    chk("nom_error", 32'(error), 32'h0);
    chk("nom_index", 32'(index), 32'd9);
    chk("nom_gap_bad", 32'(gap_bad), 32'd0);
    chk("nom_gap_n", 32'(gap_n), 32'd9);
    tick();
    tick();
    chk("nom_done_hold", 32'(done), 32'h1);

    // Restart from DONE, controller silent on entry 3 -> timeout
    new_run();
    mute_pulse = 4;
    start = 1'b1;
    s1 = cyc;
    tick();
    start = 1'b0;
    chk("to_done_clr", 32'(done), 32'h0);
    chk("to_busy_on", 32'(busy), 32'h1);
    chk("to_index0", 32'(index), 32'd0);
    for (int i = 0; i < 300 && error !== 1'b1; i++) tick();
    chk("to_err_cyc", 32'(cyc - s1), 32'd99);
    chk("to_4th_pulse", 32'(last_pulse_cyc - s1), 32'd83);
    chk("to_index", 32'(index), 32'd3);
    chk("to_done", 32'(done), 32'h0);
    chk("to_busy_off", 32'(busy), 32'h0);
    for (int i = 0; i < 40; i++) tick();
    chk("to_no_more", 32'(pulses), 32'd4);
    chk("to_err_hold", 32'(error), 32'h1);
    mute_pulse = 0;

    // Restart from ERROR; a second start during entry 5 is ignored
    new_run();
    start = 1'b1;
    s2 = cyc;
    tick();
    start = 1'b0;
    chk("re_err_clr", 32'(error), 32'h0);
    chk("re_busy_on", 32'(busy), 32'h1);
    chk("re_index0", 32'(index), 32'd0);
    for (int i = 0; i < 300 && pulses < 6; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_index5", 32'(index), 32'd5);
    chk("sb_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
    chk("sb_done_cyc", 32'(cyc - s2), 32'd271);
    chk("sb_pulses", 32'(pulses), 32'd10);
    chk("sb_gap_bad", 32'(gap_bad), 32'd0);

    // Reset while in WAIT_DONE on entry 7
    new_run();
    start = 1'b1;
    s3 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && pulses < 8; i++) tick();
    chk("mr_8th_pulse", 32'(last_pulse_cyc - s3), 32'd191);
    for (int i = 0; i < 10; i++) tick();
    chk("mr_index7", 32'(index), 32'd7);
    chk("mr_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    chk("mr_i2c_start", 32'(i2c_start), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_error", 32'(error), 32'h0);
    chk("mr_index", 32'(index), 32'h0);
    chk("mr_data_0", 32'(data_0), 32'h0);
    chk("mr_data_1", 32'(data_1), 32'h0);
    chk("mr_address", 32'(address), 32'h39);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("mr_quiet", 32'(pulses), 32'd8);
    chk("mr_idle_busy", 32'(busy), 32'h0);

    // Whole-run invariants
    chk("addr_const", 32'(addr_bad), 32'd0);
    chk("data_stable", 32'(stab_bad), 32'd0);
    chk("start_1cyc", 32'(dbl_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Downstream of the key single-shot pulse and upstream of the I2C write controller, in the 250 kHz clock domain.
- On a one-cycle start pulse, it walks a fixed 10-entry ROM of HDMI transmitter register writes.
- For each entry it presents {device address, register, value} and issues a one-cycle i2c_start, then waits for the controller's busy handshake before moving on.
- Reports progress, completion and handshake timeout.

Parameters:
- DEV_ADDR, 7'h39, 7-bit I2C device address driven on address for every entry.
- NUM_REGS, 10, number of ROM entries sent; legal range 1..16.
- GAP_CYCLES, 4, idle clk cycles between end of one transaction and the next i2c_start; legal range 1..255.
- ACK_TIMEOUT, 16, max clk cycles to wait for i2c_busy to rise after i2c_start; legal range 2..255.

Ports:
- clk, input, 1, sequencer clock (250 kHz domain).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to run the full sequence.
- i2c_busy, input, 1, high while the I2C controller is transferring.
- address, output, 7, I2C device address.
- data_0, output, 8, register index of current entry.
- data_1, output, 8, register value of current entry.
- i2c_start, output, 1, one-cycle transaction request.
- busy, output, 1, high from accepted start until DONE or ERROR.
- done, output, 1, level; high once all NUM_REGS entries completed.
- error, output, 1, level; high if a handshake timeout occurred.
- index, output, 4, ROM index of the entry in flight.

Behaviour:
- Reset and clock: single clock; reset is synchronous and active-high, on clk and rst.
- Reset values: address=DEV_ADDR, data_0=0, data_1=0, i2c_start=0, busy=0, done=0, error=0, index=0, state=IDLE.
- Reset mid-transaction returns immediately to IDLE with the above values; no further i2c_start is issued.
- ROM contents (reg, value), entries 0..9:
  - (41,10), (98,03), (9A,E0), (9C,30), (9D,61), (A2,A4), (A3,A4), (E0,D0), (F9,00), (15,00)
  - index ≥ NUM_REGS is never read.
- All outputs are registered. data_0/data_1 change only in LOAD and are held stable until the next LOAD.
- IDLE:
  - start=1 → LOAD; set busy=1, clear done and error, index=0.
  - start is also accepted from DONE and ERROR (restarts from entry 0).
  - start while busy=1 is ignored.
- LOAD: drive data_0/data_1 from ROM[index] → START (1 cycle).
- START:
  - i2c_start=1 for exactly this one cycle; clear timeout counter → WAIT_ACK.
  - i2c_start is never high in any other state.
- WAIT_ACK:
  - i2c_busy=1 → WAIT_DONE.
  - Otherwise increment counter; on reaching ACK_TIMEOUT cycles in WAIT_ACK → ERROR.
- WAIT_DONE: remain while i2c_busy=1; on i2c_busy=0 → GAP, clear gap counter.
- GAP: count GAP_CYCLES cycles, then:
  - if index==NUM_REGS-1 → DONE;
  - else index+1 and → LOAD.
- DONE: busy=0, done=1; hold until rst or start.
- ERROR: busy=0, error=1; index holds the failing entry; hold until rst or start.
- Latency from accepted start to first i2c_start: 2 cycles (start sampled in cycle n; LOAD in n+1; i2c_start high in n+2).
- i2c_busy already high when entering WAIT_ACK (controller reacts in the same cycle) counts as acknowledge.
- i2c_busy glitching high while in IDLE, GAP or DONE is ignored.
- Counters saturate and never wrap; index is 4-bit and never exceeds NUM_REGS-1.

Test Plan:
- Nominal run:
  - Stimulus: rst 2 cycles, start pulse, bench controller raises busy 1 cycle after i2c_start and holds it 20 cycles.
  - Response: exactly 10 i2c_start pulses; address=7'h39 throughout; (data_0,data_1) sequence equals the ROM list; first pulse 2 cycles after start; done=1, busy=0 after the last GAP.
- Timeout:
  - Stimulus: controller never asserts busy on entry 3.
  - Response: error=1 exactly 16 cycles after the 4th i2c_start; index=3; done=0; no further i2c_start.
- Start while busy:
  - Stimulus: second start pulse during entry 5.
  - Response: ignored; sequence completes normally with 10 pulses total.
- Reset mid-operation:
  - Stimulus: rst=1 while in WAIT_DONE on entry 7.
  - Response: next cycle all outputs at reset values; no i2c_start for 50 cycles after rst drops.
- Restart:
  - Stimulus: start after DONE, and separately start after ERROR.
  - Response: done/error cleared the next cycle; sequence re-runs from index 0.
- Gap and stability:
  - Check: between busy falling and the next i2c_start, exactly GAP_CYCLES+2 cycles.
  - Check: data_0/data_1 unchanged throughout each WAIT_ACK/WAIT_DONE.
